// File: rtl/dsp_cfg_pkg.sv
// dsp_cfg_pkg: shared state encoding and PIRDSP B-register chain bit map
package dsp_cfg_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_VERIFY, ST_DONE, ST_HOLD} state_t;
    localparam int CFG_B_LEN              = 7;
    localparam int CFG_B_INPUT            = 0;
    localparam int CFG_B_BMULTSEL         = 1;
    localparam int CFG_B_BREG_LO          = 2;
    localparam int CFG_B_BREG_HI          = 3;
    localparam int CFG_B_BCASCREG_LO      = 4;
    localparam int CFG_B_BCASCREG_HI      = 5;
    localparam int CFG_B_IS_RSTB_INVERTED = 6;
endpackage

// File: rtl/dsp_cfg_shifter.sv
// dsp_cfg_shifter: shadow word, MSB-first bit select and sticky readback compare
module dsp_cfg_shifter
    import dsp_cfg_pkg::*;
#(
    parameter int N  = CFG_B_LEN,
    parameter int KW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [N-1:0]  data,
    input  logic [KW-1:0] k,
    input  logic [KW-1:0] k_nxt,
    input  logic          cmp,
    input  logic          chain_out,
    output logic [N-1:0]  shadow,
    output logic          nxt_bit,
    output logic          mis,
    output logic          mis_nxt
);
    localparam logic [KW-1:0] TOP = KW'(N - 1);
    logic [N-1:0] shadow_nxt;
    // The registered chain input is fed from the value this edge will hold
    assign shadow_nxt = load ? data : shadow;
    assign nxt_bit    = shadow_nxt[TOP - k_nxt];
    assign mis_nxt    = load ? 1'b0 : mis | (cmp & (chain_out != shadow[TOP - k]));
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow <= '0;
            mis    <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            mis    <= mis_nxt;
        end
    end
endmodule

// File: rtl/dsp_cfg_chain_loader.sv
// dsp_cfg_chain_loader: shifts a config word into a PIRDSP chain, optional readback verify
module dsp_cfg_chain_loader
    import dsp_cfg_pkg::*;
#(
    parameter int CHAIN_LEN  = CFG_B_LEN,
    parameter int FREEZE_EXT = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHAIN_LEN-1:0] cfg_data,
    input  logic                 cfg_verify,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CHAIN_LEN-1:0] cfg_active,
    output logic                 dsp_freeze,
    output logic                 chain_cfg_in,
    output logic                 chain_cfg_en,
    input  logic                 chain_cfg_out
);
    localparam int KW = $clog2(CHAIN_LEN);
    state_t state, state_d;
    logic [KW-1:0] k, k_d;
    logic [1:0] h, h_d;
    logic vflag, accept, last, nxt_bit, mis, mis_nxt;
    logic ready_d, busy_d, done_d, err_d, freeze_d, en_d, in_d;
    logic [CHAIN_LEN-1:0] shadow;
    assign accept = cfg_valid & cfg_ready;
    assign last   = k == KW'(CHAIN_LEN - 1);
    dsp_cfg_shifter #(.N(CHAIN_LEN), .KW(KW)) u_shifter (
        .clk       (clk),
        .rstn      (rstn),
        .load      (accept),
        .data      (cfg_data),
        .k         (k),
        .k_nxt     (k_d),
        .cmp       (state == ST_VERIFY),
        .chain_out (chain_cfg_out),
        .shadow    (shadow),
        .nxt_bit   (nxt_bit),
        .mis       (mis),
        .mis_nxt   (mis_nxt)
    );
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            k            <= '0;
            h            <= '0;
            vflag        <= 1'b0;
            cfg_ready    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            dsp_freeze   <= 1'b0;
            chain_cfg_en <= 1'b0;
            chain_cfg_in <= 1'b0;
            cfg_active   <= '0;
        end else begin
            state        <= state_d;
            k            <= k_d;
            h            <= h_d;
            vflag        <= accept ? cfg_verify : vflag;
            cfg_ready    <= ready_d;
            busy         <= busy_d;
            done         <= done_d;
            err          <= err_d;
            dsp_freeze   <= freeze_d;
            chain_cfg_en <= en_d;
            chain_cfg_in <= in_d;
            if (state == ST_DONE && !mis)
                cfg_active <= shadow;
        end
    end
    always_comb begin
        state_d = state;
        k_d     = k;
        h_d     = h;
        case (state)
            ST_IDLE: if (accept) begin
                state_d = ST_LOAD;
                k_d     = '0;
            end
            ST_LOAD, ST_VERIFY: begin
                k_d = last ? '0 : k + 1'b1;
                if (last)
                    state_d = (state == ST_LOAD && vflag) ? ST_VERIFY : ST_DONE;
            end
            ST_DONE: begin
                h_d     = '0;
                state_d = FREEZE_EXT == 0 ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
                h_d = h + 1'b1;
                if (h == 2'(FREEZE_EXT - 1))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    // Outputs are decoded from the next state so they land in flops
    always_comb begin
        ready_d  = state_d == ST_IDLE;
        busy_d   = state_d == ST_LOAD || state_d == ST_VERIFY || state_d == ST_DONE;
        done_d   = state_d == ST_DONE;
        err_d    = done_d & mis_nxt;
        freeze_d = state_d != ST_IDLE;
        en_d     = state_d == ST_LOAD || state_d == ST_VERIFY;
        in_d     = en_d & nxt_bit;
    end
endmodule

// File: tb/tb_dsp_cfg_chain_loader.sv
// tb_dsp_cfg_chain_loader: directed and random requests against a 7-flop chain model
module tb_dsp_cfg_chain_loader;
    import dsp_cfg_pkg::*;
    localparam int N = CFG_B_LEN;
    localparam logic [N-1:0] STUCK_MASK = N'(1) << CFG_B_BREG_HI;
    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic cfg_valid = 1'b0;
    logic cfg_verify = 1'b0;
    logic [N-1:0] cfg_data = '0;
    logic cfg_ready, busy, done, err, dsp_freeze, chain_cfg_in, chain_cfg_en, chain_cfg_out;
    logic [N-1:0] cfg_active;
    logic [N-1:0] chain = '0;
    logic [N-1:0] exp_active = '0;
    bit stuck = 1'b0;
    int total = 0;
    int bad = 0;
    dsp_cfg_chain_loader #(.CHAIN_LEN(N), .FREEZE_EXT(1)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_data      (cfg_data),
        .cfg_verify    (cfg_verify),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .cfg_active    (cfg_active),
        .dsp_freeze    (dsp_freeze),
        .chain_cfg_in  (chain_cfg_in),
        .chain_cfg_en  (chain_cfg_en),
        .chain_cfg_out (chain_cfg_out)
    );
    always #5 clk = ~clk;
    // Stage 0 takes the input, stage N-1 drives the readback; optional stage-3 stuck-at-1
    assign chain_cfg_out = (chain | (stuck ? STUCK_MASK : '0)) >> (N - 1) != 0;
    always @(posedge clk)
        if (chain_cfg_en)
            chain <= {chain[N-2:0] | (stuck ? STUCK_MASK[N-2:0] : '0), chain_cfg_in};
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask
    task automatic rst_check();
        rstn = 1'b0;
        #1;
        chk("rst_outs", {cfg_ready, busy, done, err, dsp_freeze, chain_cfg_en, chain_cfg_in}, 0);
        chk("rst_active", cfg_active, 0);
        exp_active = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", cfg_ready, 1);
    endtask
    task automatic req(input logic [N-1:0] w, input bit v);
        int cyc, en_cnt, first_en, last_en, done_cyc, busy_low, frz_low, len;
        logic [2*N-1:0] seq;
        bit e_err;
        len = v ? 2 * N : N;
        // A stuck-at-1 stage forces every readback bit to 1
        e_err = v && stuck && w != '1;
        cyc = 0;
        @(negedge clk);
        while (!cfg_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_ready", cfg_ready, 1);
        cfg_data = w;
        cfg_verify = v;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_data = N'($urandom);
        cfg_verify = 1'($urandom);
        cyc = 0; en_cnt = 0; first_en = 0; last_en = 0; done_cyc = 0;
        busy_low = 0; frz_low = 0; seq = '0;
        while (done_cyc == 0 && cyc < 4 * N) begin
            @(negedge clk);
            cyc++;
            if (chain_cfg_en) begin
                en_cnt++;
                if (first_en == 0) first_en = cyc;
                last_en = cyc;
                seq = {seq[2*N-2:0], chain_cfg_in};
            end
            if (!busy) busy_low++;
            if (!dsp_freeze) frz_low++;
            if (done) done_cyc = cyc;
        end
        chk("done_lat", done_cyc, len + 1);
        chk("en_cnt", en_cnt, len);
        chk("en_first", first_en, 1);
        chk("en_last", last_en, len);
        chk("in_seq", seq, v ? {w, w} : {{N{1'b0}}, w});
        chk("busy_low", busy_low, 0);
        chk("freeze_low", frz_low, 0);
        chk("err", err, e_err);
        if (!stuck) chk("chain", chain, w);
        if (!e_err) exp_active = w;
        @(negedge clk);
        chk("hold", {done, busy, cfg_ready, dsp_freeze, chain_cfg_en}, 5'b00010);
        chk("active", cfg_active, exp_active);
        @(negedge clk);
        chk("idle", {cfg_ready, dsp_freeze, busy}, 3'b100);
    endtask
    task automatic abort_at(input logic [N-1:0] w, input bit v, input int ncyc);
        @(negedge clk);
        cfg_data = w;
        cfg_verify = v;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        repeat (ncyc) @(negedge clk);
        chk("pre_rst_en", chain_cfg_en, 1);
        rst_check();
    endtask
    initial begin
        int cyc, low, rdy;
        #2;
        rst_check();
        req(7'b1010011, 1'b0);
        chk("active_53", cfg_active, 7'h53);
        req(7'b0110101, 1'b1);
        stuck = 1'b1;
        req(7'h00, 1'b1);
        chk("active_kept", cfg_active, 7'h35);
        stuck = 1'b0;
        // Valid held through DONE/HOLD: the second word is only taken in IDLE
        @(negedge clk);
        cfg_data = 7'h2A;
        cfg_verify = 1'b0;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_data = 7'h15;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5_done1", cyc, N + 1);
        low = 0; rdy = 0; cyc = 0;
        while (!(low > 0 && dsp_freeze) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!dsp_freeze) low++;
            if (cfg_ready) rdy++;
        end
        cfg_valid = 1'b0;
        chk("t5_frz_low", low, 1);
        chk("t5_ready_cnt", rdy, 1);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5_done2", cyc, N);
        chk("t5_err", err, 0);
        @(negedge clk);
        chk("t5_active", cfg_active, 7'h15);
        exp_active = 7'h15;
        @(negedge clk);
        abort_at(7'h4C, 1'b1, N + 3);
        abort_at(7'h2B, 1'b0, 4);
        req(7'h7F, 1'b1);
        repeat (8) req(N'($urandom), 1'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
